sd_emmc_cmd_responder: RTL and testbench

Device-side eMMC CMD-line endpoint. It deserialises 48-bit host command frames, checks the frame and its CRC7, and presents index and argument to device logic. On request it serialises an R1/R3 (48-bit) or R2 (136-bit) response back onto CMD after the Ncr gap. It is the card end of the RAID0 command path and serves as a single-member emulator for RAID0 command-layer bring-up.

---
 rtl/sd_emmc_cmd_responder.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_sd_emmc_cmd_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_emmc_cmd_responder.sv
// ---------------------------------------------------------------------------
// sd_emmc_cmd_responder
// Card-side eMMC CMD-line endpoint. Receives 48-bit host command frames
// (start, direction, index, argument, CRC7, end), checks framing and CRC7,
// and presents the index and argument to device logic. When asked, it
// transmits a short (R1/R3, 48-bit) or long (R2, 136-bit) response after a
// gap of NCR_CYCLES released clocks.
//
// Optional build macro: SD_EMMC_R1B_BUSY_EN
//   When defined, the port busy_hold_i is added and response type 11 (R1b)
//   holds DAT0 low after the end bit for at least BUSY_MIN cycles and for as
//   long as busy_hold_i is high. When undefined, type 11 is sent as a plain
//   R1 and dat0_busy_o never leaves 1.
//
// Ports
//   sd_clk         card clock; CMD sampled and driven on the rising edge
//   rst            asynchronous active-low reset
//   cmd_i          CMD line input
//   cmd_o/cmd_oe_o CMD drive value / drive enable
//   cmd_valid_o    one-cycle pulse per accepted frame
//   cmd_crc_ok_o   received CRC7 matched (held until the next frame)
//   cmd_index_o    received command index (held)
//   cmd_arg_o      received argument (held)
//   resp_start_i   response request, honoured only while awaiting a response
//   resp_type_i    00 none, 01 R2, 10 R1/R3, 11 R1b
//   resp_r3_i      short response uses all-ones index and CRC fields
//   resp_status_i  short-response payload
//   resp_long_i    R2 payload (CID/CSD[127:8])
//   resp_busy_o    high from request acceptance through the end bit
//   resp_done_o    one-cycle pulse after the end bit
//   busy_hold_i    (optional) extend DAT0 busy
//   dat0_busy_o    DAT0 drive, active low; 1 = released
// ---------------------------------------------------------------------------
module sd_emmc_cmd_responder #(
  parameter int NCR_CYCLES = 2,
  parameter int BUSY_MIN   = 2
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe_o,
  output logic         cmd_valid_o,
  output logic         cmd_crc_ok_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  input  logic         resp_start_i,
  input  logic [1:0]   resp_type_i,
  input  logic         resp_r3_i,
  input  logic [31:0]  resp_status_i,
  input  logic [119:0] resp_long_i,
  output logic         resp_busy_o,
  output logic         resp_done_o,
`ifdef SD_EMMC_R1B_BUSY_EN
  input  logic         busy_hold_i,
`endif
  output logic         dat0_busy_o
);

  localparam logic [2:0] S_RX_IDLE   = 3'd0;
  localparam logic [2:0] S_RX_SHIFT  = 3'd1;
  localparam logic [2:0] S_WAIT_RESP = 3'd2;
  localparam logic [2:0] S_NCR       = 3'd3;
  localparam logic [2:0] S_TX_SHIFT  = 3'd4;
  localparam logic [2:0] S_BUSY      = 3'd5;

  localparam logic [7:0] NCR_LAST    = 8'(NCR_CYCLES - 1);
  localparam logic [7:0] BUSY_MIN_M1 = 8'(BUSY_MIN - 1);

  // One step of the serial CRC7 (x^7 + x^3 + 1), MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  logic         w_busy_hold;
  logic         w_r1b_en;
`ifdef SD_EMMC_R1B_BUSY_EN
  assign w_busy_hold = busy_hold_i;
  assign w_r1b_en    = 1'b1;
`else
  assign w_busy_hold = 1'b0;
  assign w_r1b_en    = 1'b0;
`endif

  logic [2:0]   r_state;
  logic [7:0]   r_cnt;
  logic [44:0]  r_rx_sr;     // frame bits 2..46 once bit 47 is on cmd_i
  logic [6:0]   r_rx_crc;
  logic [135:0] r_tx_sr;     // response image, next bit at [135]
  logic [6:0]   r_tx_crc;
  logic         r_tx_long;
  logic         r_tx_r3;
  logic         r_tx_r1b;
  logic         r_tx_end;
  logic         r_cmd_o;
  logic         r_cmd_oe;
  logic         r_valid;
  logic         r_crc_ok;
  logic [5:0]   r_index;
  logic [31:0]  r_arg;
  logic         r_busy;
  logic         r_done;
  logic         r_dat0;
  logic [7:0]   r_busy_cnt;

  logic [7:0]   w_tx_last;
  logic         w_tx_in_crc_data;
  logic         w_tx_in_crc_field;
  logic         w_tx_bit;
  logic         w_busy_start;
  logic         w_busy_release;

  assign w_tx_last         = r_tx_long ? 8'd135 : 8'd47;
  // R2 excludes its 8-bit header from the CRC; short frames cover bits 0..39.
  assign w_tx_in_crc_data  = r_tx_long ? ((r_cnt >= 8'd8) && (r_cnt <= 8'd127))
                                       : (r_cnt <= 8'd39);
  assign w_tx_in_crc_field = r_tx_long ? ((r_cnt >= 8'd128) && (r_cnt <= 8'd134))
                                       : ((r_cnt >= 8'd40) && (r_cnt <= 8'd46));
  // R3 carries a fixed all-ones CRC field that is preloaded into r_tx_sr.
  assign w_tx_bit          = (w_tx_in_crc_field && !r_tx_r3) ? r_tx_crc[6] : r_tx_sr[135];
  assign w_busy_start      = (r_state == S_TX_SHIFT) && r_tx_end && r_tx_r1b;
  assign w_busy_release    = !r_dat0 && (r_busy_cnt >= BUSY_MIN_M1) && !w_busy_hold;

  // Command receive, response sequencing and transmit shifter.
  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RX_IDLE;
      r_cnt     <= 8'd0;
      r_rx_sr   <= 45'd0;
      r_rx_crc  <= 7'd0;
      r_tx_sr   <= 136'd0;
      r_tx_crc  <= 7'd0;
      r_tx_long <= 1'b0;
      r_tx_r3   <= 1'b0;
      r_tx_r1b  <= 1'b0;
      r_tx_end  <= 1'b0;
      r_cmd_o   <= 1'b1;
      r_cmd_oe  <= 1'b0;
      r_valid   <= 1'b0;
      r_crc_ok  <= 1'b0;
      r_index   <= 6'd0;
      r_arg     <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_RX_IDLE: begin
          if (!cmd_i) begin
            r_state  <= S_RX_SHIFT;
            r_cnt    <= 8'd1;
            r_rx_crc <= 7'd0;  // start bit 0 leaves a zero CRC unchanged
          end
        end

        S_RX_SHIFT: begin
          if (r_cnt <= 8'd39) begin
            r_rx_crc <= crc7_step(r_rx_crc, cmd_i);
          end
          if ((r_cnt == 8'd1) && !cmd_i) begin
            r_state <= S_RX_IDLE;  // card-to-host direction: not for us
          end else if (r_cnt == 8'd47) begin
            if (cmd_i) begin
              r_valid  <= 1'b1;
              r_index  <= r_rx_sr[44:39];
              r_arg    <= r_rx_sr[38:7];
              r_crc_ok <= (r_rx_sr[6:0] == r_rx_crc);
              r_state  <= S_WAIT_RESP;
            end else begin
              r_state  <= S_RX_IDLE;
            end
          end else begin
            r_rx_sr <= {r_rx_sr[43:0], cmd_i};
            r_cnt   <= r_cnt + 8'd1;
          end
        end

        S_WAIT_RESP: begin
          // A new start bit takes priority over a simultaneous request.
          if (!cmd_i) begin
            r_state  <= S_RX_SHIFT;
            r_cnt    <= 8'd1;
            r_rx_crc <= 7'd0;
          end else if (resp_start_i) begin
            if (resp_type_i == 2'b00) begin
              r_state <= S_RX_IDLE;
            end else begin
              r_tx_long <= (resp_type_i == 2'b01);
              r_tx_r3   <= (resp_type_i != 2'b01) && resp_r3_i;
              r_tx_r1b  <= (resp_type_i == 2'b11) && w_r1b_en;
              if (resp_type_i == 2'b01) begin
                r_tx_sr <= {2'b00, 6'h3F, resp_long_i, 7'h00, 1'b1};
              end else begin
                r_tx_sr <= {2'b00, (resp_r3_i ? 6'h3F : r_index), resp_status_i,
                            (resp_r3_i ? 7'h7F : 7'h00), 1'b1, 88'd0};
              end
              r_tx_crc <= 7'd0;
              r_tx_end <= 1'b0;
              r_busy   <= 1'b1;
              r_cnt    <= 8'd0;
              r_state  <= S_NCR;
            end
          end
        end

        S_NCR: begin
          if (r_cnt == NCR_LAST) begin
            // Bit 0 is the start bit (0); it does not move a zero CRC.
            r_cmd_oe <= 1'b1;
            r_cmd_o  <= r_tx_sr[135];
            r_tx_sr  <= {r_tx_sr[134:0], 1'b0};
            r_cnt    <= 8'd1;
            r_state  <= S_TX_SHIFT;
          end else begin
            r_cnt    <= r_cnt + 8'd1;
          end
        end

        S_TX_SHIFT: begin
          if (r_tx_end) begin
            r_cmd_oe <= 1'b0;
            r_cmd_o  <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_tx_end <= 1'b0;
            r_cnt    <= 8'd0;
            r_state  <= r_tx_r1b ? S_BUSY : S_RX_IDLE;
          end else begin
            r_cmd_o <= w_tx_bit;
            r_tx_sr <= {r_tx_sr[134:0], 1'b0};
            if (w_tx_in_crc_data) begin
              r_tx_crc <= crc7_step(r_tx_crc, r_tx_sr[135]);
            end else if (w_tx_in_crc_field) begin
              r_tx_crc <= {r_tx_crc[5:0], 1'b0};
            end
            // Counter parks on the end bit rather than running past 135.
            if (r_cnt == w_tx_last) begin
              r_tx_end <= 1'b1;
            end else begin
              r_cnt    <= r_cnt + 8'd1;
            end
          end
        end

        S_BUSY: begin
          if (!cmd_i) begin
            r_state  <= S_RX_SHIFT;
            r_cnt    <= 8'd1;
            r_rx_crc <= 7'd0;
          end else if (w_busy_release || r_dat0) begin
            r_state  <= S_RX_IDLE;
          end
        end

        default: begin
          r_state <= S_RX_IDLE;
        end
      endcase
    end
  end

  // DAT0 busy timer; runs independently so a new command can arrive meanwhile.
  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      r_dat0     <= 1'b1;
      r_busy_cnt <= 8'd0;
    end else if (w_busy_start) begin
      r_dat0     <= 1'b0;
      r_busy_cnt <= 8'd0;
    end else if (!r_dat0) begin
      if (w_busy_release) begin
        r_dat0 <= 1'b1;
      end else if (r_busy_cnt != 8'hFF) begin
        r_busy_cnt <= r_busy_cnt + 8'd1;
      end
    end
  end

  assign cmd_o        = r_cmd_o;
  assign cmd_oe_o     = r_cmd_oe;
  assign cmd_valid_o  = r_valid;
  assign cmd_crc_ok_o = r_crc_ok;
  assign cmd_index_o  = r_index;
  assign cmd_arg_o    = r_arg;
  assign resp_busy_o  = r_busy;
  assign resp_done_o  = r_done;
  assign dat0_busy_o  = r_dat0;

endmodule

// File: tb/tb_sd_emmc_cmd_responder.sv
module tb_sd_emmc_cmd_responder;

  logic         sd_clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_i = 1'b1;
  logic         cmd_o;
  logic         cmd_oe_o;
  logic         cmd_valid_o;
  logic         cmd_crc_ok_o;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         resp_start_i = 1'b0;
  logic [1:0]   resp_type_i = 2'b00;
  logic         resp_r3_i = 1'b0;
  logic [31:0]  resp_status_i = 32'd0;
  logic [119:0] resp_long_i = 120'd0;
  logic         resp_busy_o;
  logic         resp_done_o;
  logic         dat0_busy_o;
`ifdef SD_EMMC_R1B_BUSY_EN
  logic         busy_hold_i = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  sd_emmc_cmd_responder #(.NCR_CYCLES(2), .BUSY_MIN(2)) dut (
    .sd_clk        (sd_clk),
    .rst           (rst),
    .cmd_i         (cmd_i),
    .cmd_o         (cmd_o),
    .cmd_oe_o      (cmd_oe_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_crc_ok_o  (cmd_crc_ok_o),
    .cmd_index_o   (cmd_index_o),
    .cmd_arg_o     (cmd_arg_o),
    .resp_start_i  (resp_start_i),
    .resp_type_i   (resp_type_i),
    .resp_r3_i     (resp_r3_i),
    .resp_status_i (resp_status_i),
    .resp_long_i   (resp_long_i),
    .resp_busy_o   (resp_busy_o),
    .resp_done_o   (resp_done_o),
`ifdef SD_EMMC_R1B_BUSY_EN
    .busy_hold_i   (busy_hold_i),
`endif
    .dat0_busy_o   (dat0_busy_o)
  );

  always #5 sd_clk = ~sd_clk;

  typedef struct {
    logic [47:0] frame;
    logic        valid;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc_ok;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CRC7 as polynomial long division of d[n-1:0]*x^7 by x^7+x^3+1 (0x89).
  function automatic logic [6:0] crc7_ref(input logic [119:0] d, input int n);
    logic [126:0] r;
    r = 127'(d) << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_ref(120'(h), 40), 1'b1};
  endfunction

  function automatic logic [47:0] mk_short(input logic [5:0] idx, input logic [31:0] st);
    logic [39:0] h;
    h = {2'b00, idx, st};
    return {h, crc7_ref(120'(h), 40), 1'b1};
  endfunction

  // Call at a falling edge; returns at the falling edge where cmd_valid_o is due.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      cmd_i = f[i];
      @(negedge sd_clk);
      resp_start_i = 1'b0;
    end
    cmd_i = 1'b1;
  endtask

  // Issue a request and capture the driven bits; stops early at bit stop_at.
  task automatic run_resp(input logic [1:0] typ, input logic r3, input logic [31:0] st,
                          input logic [119:0] lng, input int stop_at, input bit jam,
                          output logic [135:0] bits, output int nb, output int nlow);
    resp_type_i   = typ;
    resp_r3_i     = r3;
    resp_status_i = st;
    resp_long_i   = lng;
    resp_start_i  = 1'b1;
    @(negedge sd_clk);
    resp_start_i  = 1'b0;
    chk("busy after accept", resp_busy_o, 1'b1);
    nlow = 0;
    nb   = 0;
    bits = '0;
    for (int t = 0; t < 20 && !cmd_oe_o; t++) begin
      nlow++;
      @(negedge sd_clk);
    end
    while (cmd_oe_o && nb < 140 && nb != stop_at) begin
      bits  = {bits[134:0], cmd_o};
      nb++;
      cmd_i = (jam && nb < 30) ? 1'b0 : 1'b1;
      @(negedge sd_clk);
    end
    cmd_i = 1'b1;
  endtask

  task automatic finish_chk(input string name);
    chk({name, " done"}, resp_done_o, 1'b1);
    chk({name, " busy clr"}, resp_busy_o, 1'b0);
    chk({name, " oe off"}, cmd_oe_o, 1'b0);
    chk({name, " cmd idle"}, cmd_o, 1'b1);
    @(negedge sd_clk);
    chk({name, " done pulse"}, resp_done_o, 1'b0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " cmd_o"}, cmd_o, 1'b1);
    chk({name, " oe"}, cmd_oe_o, 1'b0);
    chk({name, " valid"}, cmd_valid_o, 1'b0);
    chk({name, " crc_ok"}, cmd_crc_ok_o, 1'b0);
    chk({name, " index"}, cmd_index_o, 6'd0);
    chk({name, " arg"}, cmd_arg_o, 32'd0);
    chk({name, " busy"}, resp_busy_o, 1'b0);
    chk({name, " done"}, resp_done_o, 1'b0);
    chk({name, " dat0"}, dat0_busy_o, 1'b1);
  endtask

  initial begin
    logic [135:0] bits;
    int nb;
    int nlow;

    tbl[0] = '{48'h400000000095, 1'b1, 6'h00, 32'h00000000, 1'b1};  // CMD0
    tbl[1] = '{48'h510000000055, 1'b1, 6'h11, 32'h00000000, 1'b1};  // CMD17
    tbl[2] = '{48'h510000000057, 1'b1, 6'h11, 32'h00000000, 1'b0};  // bad CRC
    tbl[3] = '{48'h400000000094, 1'b0, 6'h11, 32'h00000000, 1'b0};  // end bit 0
    tbl[4] = '{48'h3FFFFFFFFFFF, 1'b0, 6'h11, 32'h00000000, 1'b0};  // direction 0
    tbl[5] = '{48'h48000001AA87, 1'b1, 6'h08, 32'h000001AA, 1'b1};  // CMD8
    tbl[6] = '{48'h770000000065, 1'b1, 6'h37, 32'h00000000, 1'b1};  // CMD55

    #12;
    chk_reset_vals("reset");
    @(negedge sd_clk);
    rst = 1'b1;
    repeat (2) @(negedge sd_clk);

    for (int k = 0; k < 7; k++) begin
      send_frame(tbl[k].frame);
      chk($sformatf("v%0d valid", k), cmd_valid_o, tbl[k].valid);
      chk($sformatf("v%0d index", k), cmd_index_o, tbl[k].idx);
      if (tbl[k].valid) begin
        chk($sformatf("v%0d arg", k), cmd_arg_o, tbl[k].arg);
        chk($sformatf("v%0d crc_ok", k), cmd_crc_ok_o, tbl[k].crc_ok);
      end
      @(negedge sd_clk);
      chk($sformatf("v%0d valid pulse", k), cmd_valid_o, 1'b0);
      repeat (2) @(negedge sd_clk);
    end

    // Type 00 returns to idle; a later request outside WAIT_RESP is ignored.
    resp_type_i  = 2'b00;
    resp_start_i = 1'b1;
    @(negedge sd_clk);
    resp_start_i = 1'b0;
    chk("type00 busy", resp_busy_o, 1'b0);
    resp_type_i  = 2'b10;
    resp_start_i = 1'b1;
    @(negedge sd_clk);
    resp_start_i = 1'b0;
    chk("idle req busy", resp_busy_o, 1'b0);
    repeat (4) @(negedge sd_clk);
    chk("idle req oe", cmd_oe_o, 1'b0);

    // R1 for CMD17.
    send_frame(48'h510000000055);
    run_resp(2'b10, 1'b0, 32'h00000900, 120'd0, -1, 1'b0, bits, nb, nlow);
    chk("r1 ncr gap", nlow, 2);
    chk("r1 length", nb, 48);
    chk("r1 bits", bits, 136'(mk_short(6'h11, 32'h00000900)));
    finish_chk("r1");

    // R3 for CMD1, with cmd_i pulled low during transmit (must be ignored).
    send_frame(mk_frame(6'd1, 32'h40FF8000));
    chk("cmd1 index", cmd_index_o, 6'd1);
    chk("cmd1 crc_ok", cmd_crc_ok_o, 1'b1);
    run_resp(2'b10, 1'b1, 32'hC0FF8080, 120'd0, -1, 1'b1, bits, nb, nlow);
    chk("r3 length", nb, 48);
    chk("r3 bits", bits, 136'({2'b00, 6'h3F, 32'hC0FF8080, 7'h7F, 1'b1}));
    finish_chk("r3");
    chk("r3 no rx", cmd_valid_o, 1'b0);

    // R2 for CMD2.
    send_frame(48'h42000000004D);
    chk("cmd2 crc_ok", cmd_crc_ok_o, 1'b1);
    run_resp(2'b01, 1'b0, 32'd0, 120'h1, -1, 1'b0, bits, nb, nlow);
    chk("r2 ncr gap", nlow, 2);
    chk("r2 length", nb, 136);
    chk("r2 bits", bits, {2'b00, 6'h3F, 120'h1, crc7_ref(120'h1, 120), 1'b1});
    finish_chk("r2");

    // Simultaneous request and start bit: the new frame wins.
    send_frame(48'h510000000055);
    resp_type_i  = 2'b10;
    resp_r3_i    = 1'b0;
    resp_start_i = 1'b1;
    send_frame(48'h400000000095);
    chk("race valid", cmd_valid_o, 1'b1);
    chk("race index", cmd_index_o, 6'd0);
    chk("race busy", resp_busy_o, 1'b0);
    repeat (4) @(negedge sd_clk);
    chk("race oe", cmd_oe_o, 1'b0);

    // Type 11 (R1b) for CMD13.
    send_frame(mk_frame(6'd13, 32'h00010000));
`ifdef SD_EMMC_R1B_BUSY_EN
    busy_hold_i = 1'b1;
`endif
    run_resp(2'b11, 1'b0, 32'h00000900, 120'd0, -1, 1'b0, bits, nb, nlow);
    chk("r1b length", nb, 48);
    chk("r1b bits", bits, 136'(mk_short(6'd13, 32'h00000900)));
`ifdef SD_EMMC_R1B_BUSY_EN
    chk("r1b done", resp_done_o, 1'b1);
    nlow = 0;
    for (int k = 0; k < 10; k++) begin
      if (!dat0_busy_o) nlow++;
      if (k == 9) busy_hold_i = 1'b0;
      @(negedge sd_clk);
    end
    chk("r1b dat0 low cycles", nlow, 10);
    chk("r1b dat0 release", dat0_busy_o, 1'b1);
`else
    chk("r1b dat0", dat0_busy_o, 1'b1);
    finish_chk("r1b");
`endif
    repeat (2) @(negedge sd_clk);

    // Reset asserted at TX bit 20 releases CMD at once.
    send_frame(48'h510000000055);
    run_resp(2'b10, 1'b0, 32'h00000900, 120'd0, 20, 1'b0, bits, nb, nlow);
    chk("pre-reset oe", cmd_oe_o, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("mid-tx reset");
    @(negedge sd_clk);
    rst = 1'b1;
    repeat (2) @(negedge sd_clk);
    send_frame(48'h400000000095);
    chk("post-reset valid", cmd_valid_o, 1'b1);
    chk("post-reset crc_ok", cmd_crc_ok_o, 1'b1);
    chk("post-reset index", cmd_index_o, 6'd0);
    send_frame(48'h48000001AA87);
    chk("post-reset cmd8 arg", cmd_arg_o, 32'h000001AA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
